i2s_tx_serializer: RTL and testbench

- Consumes the 32-bit signed mono sample stream (`sample_valid`/`audio_in`) produced by the effect chain, e.g. `delay_effect`.
- Serializes that stream into a standard I2S frame (`bclk`, `lrclk`, `sdata`) for the board DAC.
- Internal clock divider generates all I2S timing; a one-entry holding register decouples the bursty valid stream from the frame rate.
- Reports underrun and overflow conditions through sticky flags.

---
 rtl/i2s_tx_serializer_if.sv | 13 +
 rtl/i2s_tx_serializer.sv | 128 ++++++++++++
 tb/tb_i2s_tx_serializer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// Sample stream in, I2S serial lines out, for i2s_tx_serializer.
interface i2s_tx_serializer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                         sample_valid;
   logic signed [DATA_WIDTH-1:0] audio_in;
   logic                         bclk;
   logic                         lrclk;
   logic                         sdata;

   modport master (output sample_valid, audio_in, input bclk, lrclk, sdata);
   modport slave  (input sample_valid, audio_in, output bclk, lrclk, sdata);
endinterface

// File: rtl/i2s_tx_serializer.sv
// Mono sample stream to I2S serializer with one-entry holding register and sticky flags.
// Optional: define I2S_TX_UNDERRUN_MUTE_EN to send silence instead of repeating on underrun.
module i2s_tx_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_BITS   = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int BCLK_DIV   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_flags,
   i2s_tx_serializer_if.slave      bus,
   output logic                    frame_start,
   output logic                    underrun,
   output logic                    overflow
);
   localparam int FRAME = 2 * SLOT_WIDTH;
   localparam int CW    = $clog2(BCLK_DIV);
   localparam int BW    = $clog2(FRAME);
   localparam int SW    = $clog2(SLOT_WIDTH);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  bclk_q, bclk_d;
   logic                  lrclk_q, lrclk_d;
   logic                  sdata_q, sdata_d;
   logic                  frame_start_q, frame_start_d;
   logic                  underrun_q, underrun_d;
   logic                  overflow_q, overflow_d;
   logic                  hold_full_q, hold_full_d;
   logic [SLOT_WIDTH-1:0] hold_q, hold_d;
   logic [SLOT_WIDTH-1:0] word_q, word_d;   // current frame word; doubles as last-word
   logic [SLOT_WIDTH-1:0] in_word;
   logic [BW-1:0]         k;
   logic [SW-1:0]         idx;
   logic                  tick, fall, load, underrun_set, overflow_set;
   logic                  unused_audio;

   assign unused_audio = ^bus.audio_in;

   always_comb begin
      tick   = (cnt_q == CW'(BCLK_DIV - 1));
      cnt_d  = tick ? '0 : cnt_q + CW'(1);
      bclk_d = tick ? ~bclk_q : bclk_q;
      fall   = tick & bclk_q;
      load   = fall & (bit_cnt_q == BW'(FRAME - 1));

      in_word = '0;
      in_word[SLOT_WIDTH-1 -: OUT_BITS] = bus.audio_in[DATA_WIDTH-1 -: OUT_BITS];

      word_d       = word_q;
      underrun_set = 1'b0;
      if (load) begin
         if (hold_full_q)
            word_d = hold_q;
         else if (bus.sample_valid)
            word_d = in_word;
         else begin
            underrun_set = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            word_d = '0;
`endif
         end
      end

      // A write on a load with the register empty bypasses into the frame instead.
      hold_d       = hold_q;
      hold_full_d  = hold_full_q & ~load;
      overflow_set = 1'b0;
      if (bus.sample_valid && !(load && !hold_full_q)) begin
         hold_d       = in_word;
         hold_full_d  = 1'b1;
         overflow_set = hold_full_q & ~load;
      end

      bit_cnt_d = bit_cnt_q;
      if (fall)
         bit_cnt_d = (bit_cnt_q == BW'(FRAME - 1)) ? '0 : bit_cnt_q + BW'(1);
      k   = (bit_cnt_d >= BW'(SLOT_WIDTH)) ? bit_cnt_d - BW'(SLOT_WIDTH) : bit_cnt_d;
      idx = SW'(BW'(SLOT_WIDTH - 1) - k);

      sdata_d = sdata_q;
      lrclk_d = lrclk_q;
      if (fall) begin
         sdata_d = word_d[idx];
         lrclk_d = (bit_cnt_d >= BW'(SLOT_WIDTH - 1)) && (bit_cnt_d != BW'(FRAME - 1));
      end

      frame_start_d = load;
      underrun_d    = underrun_set | (underrun_q & ~clear_flags);
      overflow_d    = overflow_set | (overflow_q & ~clear_flags);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q         <= '0;
         bit_cnt_q     <= BW'(FRAME - 1);
         bclk_q        <= 1'b0;
         lrclk_q       <= 1'b0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         overflow_q    <= 1'b0;
         hold_full_q   <= 1'b0;
         hold_q        <= '0;
         word_q        <= '0;
      end else begin
         cnt_q         <= cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         bclk_q        <= bclk_d;
         lrclk_q       <= lrclk_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         overflow_q    <= overflow_d;
         hold_full_q   <= hold_full_d;
         hold_q        <= hold_d;
         word_q        <= word_d;
      end
   end

   assign bus.bclk    = bclk_q;
   assign bus.lrclk   = lrclk_q;
   assign bus.sdata   = sdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
   assign overflow    = overflow_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: scoreboard of expected slot words vs captured frames.
module tb_i2s_tx_serializer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic clear_flags = 1'b0;
   logic frame_start, underrun, overflow;
   logic fs2, ur2, ov2;
   logic clr2 = 1'b0;

   always #5 clk = ~clk;

   i2s_tx_serializer_if #(.DATA_WIDTH(32)) bus ();
   i2s_tx_serializer_if #(.DATA_WIDTH(32)) bus2 ();

   i2s_tx_serializer #(.DATA_WIDTH(32), .OUT_BITS(24), .SLOT_WIDTH(32), .BCLK_DIV(8)) dut (
      .clk(clk), .reset(reset), .clear_flags(clear_flags), .bus(bus),
      .frame_start(frame_start), .underrun(underrun), .overflow(overflow));

   i2s_tx_serializer #(.DATA_WIDTH(32), .OUT_BITS(24), .SLOT_WIDTH(32), .BCLK_DIV(2)) dut_t (
      .clk(clk), .reset(reset), .clear_flags(clr2), .bus(bus2),
      .frame_start(fs2), .underrun(ur2), .overflow(ov2));

   int tests_run = 0;
   int fails = 0;
   logic [31:0] sb[$];
   localparam logic [63:0] LR_EXP = {31'h0, 32'hFFFF_FFFF, 1'b0};

   initial begin
      bus.sample_valid = 1'b0; bus.audio_in = '0;
      bus2.sample_valid = 1'b0; bus2.audio_in = '0;
   end

   function automatic logic [31:0] slot_of(input logic [31:0] s);
      return {s[31:8], 8'h00};
   endfunction

   // Called at a negedge; holds sample_valid for exactly one posedge.
   task automatic drive_sample(input logic [31:0] s, input bit expect_sent);
      bus.sample_valid = 1'b1;
      bus.audio_in     = s;
      if (expect_sent) sb.push_back(slot_of(s));
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic pop_exp(output logic [31:0] e);
      if (sb.size() == 0) e = 'x;
      else e = sb.pop_front();
   endtask

   task automatic do_reset;
      reset = 1'b0;
      bus.sample_valid = 1'b0;
      clear_flags = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      sb.delete();
   endtask

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (frame_start === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         tests_run++; fails++;
         $display("FAIL frame_start_timeout: no frame_start within 3000 cycles");
      end
   endtask

   task automatic wait_bclk(input logic v, inout bit ok);
      int t = 0;
      while (bus.bclk !== v && t < 100) begin @(negedge clk); t++; end
      if (bus.bclk !== v) begin
         tests_run++; fails++; ok = 1'b0;
         $display("FAIL bclk_timeout: bclk=%b want %b", bus.bclk, v);
      end
   endtask

   // Receiver view: sample sdata/lrclk on each rising bclk, starting at the frame load.
   task automatic capture(output logic [63:0] data, output logic [63:0] lr, output bit ok);
      data = 'x; lr = 'x;
      wait_fs(ok);
      for (int i = 0; i < 64 && ok; i++) begin
         wait_bclk(1'b0, ok);
         if (ok) wait_bclk(1'b1, ok);
         data[63-i] = bus.sdata;
         lr[63-i]   = bus.lrclk;
      end
   endtask

   task automatic test_reset;
      repeat (5) @(negedge clk);
      tests_run++;
      if ({bus.bclk, bus.lrclk, bus.sdata, frame_start, underrun, overflow} !== 6'b0) begin
         fails++; $display("FAIL reset_initial: outputs=%b want 000000",
            {bus.bclk, bus.lrclk, bus.sdata, frame_start, underrun, overflow});
      end
      reset = 1'b1;
      repeat (600) @(negedge clk);
      tests_run++;
      if (underrun !== 1'b1) begin fails++; $display("FAIL reset_prerun_underrun: got %b want 1", underrun); end
      tests_run++;
      if (bus.lrclk !== 1'b1) begin fails++; $display("FAIL reset_prerun_lrclk: got %b want 1", bus.lrclk); end
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.bclk, bus.lrclk, bus.sdata, frame_start, underrun, overflow} !== 6'b0) begin
            fails++; $display("FAIL reset_midframe[%0d]: outputs=%b want 000000", c,
               {bus.bclk, bus.lrclk, bus.sdata, frame_start, underrun, overflow});
         end
      end
      reset = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 7 || c == 8 || c == 15 || c == 16) begin
            logic [1:0] want;
            want = (c == 7) ? 2'b00 : (c == 16) ? 2'b01 : 2'b10;
            tests_run++;
            if ({bus.bclk, frame_start} !== want) begin
               fails++; $display("FAIL reset_release_cycle%0d: {bclk,frame_start}=%b want %b",
                  c, {bus.bclk, frame_start}, want);
            end
         end
      end
   endtask

   task automatic test_data_format;
      logic [63:0] d, lr; logic [31:0] e; bit ok;
      do_reset();
      drive_sample(32'h8000_0001, 1'b1);
      capture(d, lr, ok);
      pop_exp(e);
      tests_run++;
      if (d !== {e, e}) begin fails++; $display("FAIL format_data: got %h want %h", d, {e, e}); end
      tests_run++;
      if (lr !== LR_EXP) begin fails++; $display("FAIL format_lrclk: got %h want %h", lr, LR_EXP); end
      tests_run++;
      if (underrun !== 1'b0) begin fails++; $display("FAIL format_underrun: got %b want 0", underrun); end
   endtask

   task automatic test_underrun;
      logic [63:0] d, lr; logic [31:0] e; bit ok;
      do_reset();
      drive_sample(32'h1234_5600, 1'b1);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
      sb.push_back(32'h0);
`else
      sb.push_back(slot_of(32'h1234_5600));
`endif
      capture(d, lr, ok);
      pop_exp(e);
      tests_run++;
      if (d !== {e, e}) begin fails++; $display("FAIL underrun_frame1: got %h want %h", d, {e, e}); end
      tests_run++;
      if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_flag1: got %b want 0", underrun); end
      capture(d, lr, ok);
      pop_exp(e);
      tests_run++;
      if (d !== {e, e}) begin fails++; $display("FAIL underrun_frame2: got %h want %h", d, {e, e}); end
      tests_run++;
      if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_flag2: got %b want 1", underrun); end
   endtask

   task automatic test_overflow;
      logic [63:0] d, lr; logic [31:0] e; bit ok;
      do_reset();
      wait_fs(ok);
      repeat (20) @(negedge clk);
      drive_sample(32'h1111_1100, 1'b0);
      repeat (20) @(negedge clk);
      drive_sample(32'h2222_2200, 1'b1);
      tests_run++;
      if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set: got %b want 1", overflow); end
      capture(d, lr, ok);
      pop_exp(e);
      tests_run++;
      if (d !== {e, e}) begin fails++; $display("FAIL overflow_frame: got %h want %h", d, {e, e}); end
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      tests_run++;
      if ({overflow, underrun} !== 2'b00) begin
         fails++; $display("FAIL overflow_clear: {overflow,underrun}=%b want 00", {overflow, underrun});
      end
      // Set and clear on the same cycle: set wins.
      wait_fs(ok);
      repeat (20) @(negedge clk);
      drive_sample(32'h3333_3300, 1'b0);
      clear_flags = 1'b1;
      drive_sample(32'h4444_4400, 1'b0);
      clear_flags = 1'b0;
      tests_run++;
      if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set_vs_clear: got %b want 1", overflow); end
   endtask

   task automatic test_bypass;
      logic [63:0] d, lr; logic [31:0] e; bit ok;
      do_reset();
      wait_fs(ok);
      @(negedge clk); clear_flags = 1'b1;
      @(negedge clk); clear_flags = 1'b0;
      repeat (1021) @(negedge clk);
      drive_sample(32'h55AA_3300, 1'b1);
      capture(d, lr, ok);
      pop_exp(e);
      tests_run++;
      if (d !== {e, e}) begin fails++; $display("FAIL bypass_frame: got %h want %h", d, {e, e}); end
      tests_run++;
      if (underrun !== 1'b0) begin fails++; $display("FAIL bypass_underrun: got %b want 0", underrun); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] d, lr; logic [31:0] e; bit ok;
      do_reset();
      wait_fs(ok);
      repeat (10) @(negedge clk);
      drive_sample(32'hA5A5_A500, 1'b1);
      repeat (1012) @(negedge clk);
      drive_sample(32'h0F0F_0F00, 1'b1);
      capture(d, lr, ok);
      pop_exp(e);
      tests_run++;
      if (d !== {e, e}) begin fails++; $display("FAIL b2b_old_word: got %h want %h", d, {e, e}); end
      capture(d, lr, ok);
      pop_exp(e);
      tests_run++;
      if (d !== {e, e}) begin fails++; $display("FAIL b2b_new_word: got %h want %h", d, {e, e}); end
      tests_run++;
      if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return bus2.bclk;
         1:       return bus2.lrclk;
         default: return fs2;
      endcase
   endfunction

   task automatic measure(input int sel, output int per);
      int t = 0;
      while (sig(sel) !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
      while (sig(sel) !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
      per = 0;
      while (sig(sel) !== 1'b0 && per < 1000) begin @(negedge clk); per++; end
      while (sig(sel) !== 1'b1 && per < 1000) begin @(negedge clk); per++; end
   endtask

   task automatic test_timing;
      int per;
      measure(0, per);
      tests_run++;
      if (per !== 4) begin fails++; $display("FAIL timing_bclk_period: got %0d want 4", per); end
      measure(1, per);
      tests_run++;
      if (per !== 256) begin fails++; $display("FAIL timing_lrclk_period: got %0d want 256", per); end
      measure(2, per);
      tests_run++;
      if (per !== 256) begin fails++; $display("FAIL timing_frame_start_period: got %0d want 256", per); end
   endtask

   initial begin
      test_reset();
      test_data_format();
      test_underrun();
      test_overflow();
      test_bypass();
      test_back_to_back();
      test_timing();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
